// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths and FSM encoding for the 256-bit line to 64-bit burst adaptor.
package cacheline_adaptor_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int CNT_W  = 2;
  localparam int ADDR_W = 32;
  localparam int OFS_W  = 5;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the adaptor.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [ADDR_W-1:0] address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [BEAT_W-1:0] burst_i;
  logic [BEAT_W-1:0] burst_o;
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one cache line read/write into a 4-beat memory burst and answers the
// cache with a single-cycle resp_o per line.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);

  adaptor_state_t    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_beat;

  assign last_beat = bus.resp_i && (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rline_q <= '0;
      wline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rline_q <= rline_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
    end
  end

  // Read and write lines live in separate registers so a write never
  // disturbs the last read line still visible on line_o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rline_d = rline_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.read_i) begin
          state_d = READ;
          addr_d  = bus.address_i;
          cnt_d   = '0;
        end else if (bus.write_i) begin
          state_d = WRITE;
          addr_d  = bus.address_i;
          wline_d = bus.line_i;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_d[BEAT_W*int'(cnt_q) +: BEAT_W] = bus.burst_i;
          cnt_d = cnt_q + 1'b1;
        end
        if (last_beat) state_d = DONE;
      end
      WRITE: begin
        if (bus.resp_i) cnt_d = cnt_q + 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.read_o    = (state_q == READ);
    bus.write_o   = (state_q == WRITE);
    bus.resp_o    = (state_q == DONE);
    bus.address_o = {addr_q[ADDR_W-1:OFS_W], OFS_W'(0)};
    bus.burst_o   = wline_q[BEAT_W*int'(cnt_q) +: BEAT_W];
    bus.line_o    = rline_q;
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a line-level model tracks the
// expected read line and the beat order, checked every cycle on negedge.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  cacheline_adaptor_if bus();

  cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] rl_m = '0;  // line the cache should currently see on line_o

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic phase_chk(input bit is_rd, input logic [31:0] exp_a,
                           input logic [255:0] line, input int j);
    chk("burst_read_o", 256'(bus.read_o), 256'(is_rd));
    chk("burst_write_o", 256'(bus.write_o), 256'(!is_rd));
    chk("burst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("address_o", 256'(bus.address_o), 256'(exp_a));
    chk("burst_line_o", bus.line_o, rl_m);
    if (!is_rd) chk("burst_o", 256'(bus.burst_o), 256'(line[64*j +: 64]));
  endtask

  // One line transfer; gaps holds 2-bit idle counts before each beat.
  task automatic xfer(input bit is_rd, input bit both, input logic [31:0] addr,
                      input logic [255:0] line, input logic [7:0] gaps);
    logic [31:0] exp_a;
    exp_a = {addr[31:5], 5'b0};
    @(negedge clk);
    chk("idle_read_o", 256'(bus.read_o), 256'(0));
    chk("idle_write_o", 256'(bus.write_o), 256'(0));
    chk("idle_resp_o", 256'(bus.resp_o), 256'(0));
    bus.address_i = addr;
    if (is_rd) begin
      bus.read_i  = 1'b1;
      bus.write_i = both;
    end else begin
      bus.write_i = 1'b1;
      bus.line_i  = line;
    end
    for (int j = 0; j < 4; j++) begin
      for (int g = 0; g < int'(gaps[2*j +: 2]); g++) begin
        @(negedge clk);
        phase_chk(is_rd, exp_a, line, j);
        bus.resp_i  = 1'b0;
        bus.burst_i = {$urandom, $urandom};
      end
      @(negedge clk);
      phase_chk(is_rd, exp_a, line, j);
      if (!both) begin
        bus.address_i = $urandom;
        bus.line_i    = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
      end
      bus.resp_i  = 1'b1;
      bus.burst_i = is_rd ? line[64*j +: 64] : {$urandom, $urandom};
      if (is_rd) rl_m[64*j +: 64] = line[64*j +: 64];
    end
    @(negedge clk);
    bus.resp_i = 1'b0;
    chk("done_resp_o", 256'(bus.resp_o), 256'(1));
    chk("done_read_o", 256'(bus.read_o), 256'(0));
    chk("done_write_o", 256'(bus.write_o), 256'(0));
    chk("done_line_o", bus.line_o, rl_m);
    if (is_rd) bus.read_i = 1'b0;
    else       bus.write_i = 1'b0;
  endtask

  initial begin
    logic [255:0] l0, l1;
    rst = 1'b1;
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_o", 256'(bus.resp_o), 256'(0));
    chk("rst_read_o", 256'(bus.read_o), 256'(0));
    chk("rst_write_o", 256'(bus.write_o), 256'(0));
    chk("rst_line_o", bus.line_o, 256'(0));
    chk("rst_address_o", 256'(bus.address_o), 256'(0));
    chk("rst_burst_o", 256'(bus.burst_o), 256'(0));
    rst = 1'b0;

    // contiguous read, then the same line with a 2-cycle gap before beat 2
    l0 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    xfer(1'b1, 1'b0, 32'h0000_1234, l0, 8'h00);
    xfer(1'b1, 1'b0, 32'h0000_1234, l0, 8'b00_10_00_00);

    // write of {D,C,B,A} with gaps
    l1 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    xfer(1'b0, 1'b0, 32'h8000_0040, l1, 8'b01_00_11_00);

    // read and write together: read first, write after one idle cycle
    l0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.line_i = l1 ^ {8{32'h5A5A_0F0F}};
    xfer(1'b1, 1'b1, 32'h0000_2000, l0, 8'b00_01_00_00);
    xfer(1'b0, 1'b0, 32'h0000_3000, l1 ^ {8{32'h5A5A_0F0F}}, 8'h00);

    // reset after two read beats
    @(negedge clk);
    bus.address_i = 32'h0000_4444; bus.read_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("pre_rst_read_o", 256'(bus.read_o), 256'(1));
      bus.resp_i = 1'b1; bus.burst_i = {$urandom, $urandom};
      if (j == 2) rst = 1'b1;
    end
    @(negedge clk);
    rl_m = '0;
    chk("abort_read_o", 256'(bus.read_o), 256'(0));
    chk("abort_resp_o", 256'(bus.resp_o), 256'(0));
    chk("abort_line_o", bus.line_o, rl_m);
    rst = 1'b0; bus.read_i = 1'b0; bus.resp_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_resp_o", 256'(bus.resp_o), 256'(0));
    end
    l0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xfer(1'b1, 1'b0, 32'h0000_5555, l0, 8'h00);

    // stray beats while idle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_resp_o", 256'(bus.resp_o), 256'(0));
      chk("stray_read_o", 256'(bus.read_o), 256'(0));
      chk("stray_write_o", 256'(bus.write_o), 256'(0));
      chk("stray_line_o", bus.line_o, rl_m);
      bus.resp_i = 1'b1; bus.burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("stray_end_resp_o", 256'(bus.resp_o), 256'(0));
    chk("stray_end_line_o", bus.line_o, rl_m);
    bus.resp_i = 1'b0;

    // random mix
    for (int n = 0; n < 20; n++) begin
      l0 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      xfer(1'($urandom), 1'b0, $urandom, l0, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the 256-bit line-granular physical-memory port of the cache to a 64-bit burst memory. Each cache read or write becomes a 4-beat burst. Read beats are assembled into one line, and write lines are serialised into beats. Sits between the cache's pmem_* port and the off-chip memory model/controller, and answers the cache with a single-cycle response per line.

## Interface
- No parameters; widths are fixed by package constants (see Structure).
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- line_i  input  256  write line from cache (pmem_wdata)
- line_o  output  256  assembled read line to cache (pmem_rdata)
- address_i  input  32  line address from cache (pmem_address)
- read_i  input  1  cache line read request, level, held until resp_o
- write_i  input  1  cache line write request, level, held until resp_o
- resp_o  output  1  one-cycle completion pulse to cache
- burst_i  input  64  read beat from memory
- burst_o  output  64  write beat to memory
- address_o  output  32  burst base address to memory
- read_o  output  1  memory burst read request
- write_o  output  1  memory burst write request
- resp_i  input  1  memory beat strobe; one beat per cycle it is high

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, read_i=1: latch address_i. Next state is READ. Beat counter cleared.
- IDLE, write_i=1, read_i=0: latch address_i and line_i. Next state is WRITE. Beat counter cleared.
- IDLE, both asserted: read wins. The write stays pending while the cache holds write_i.
- address_o = {latched_addr[31:5], 5'b0}. The low 5 bits of address_i are always dropped.
- READ: read_o=1.
  - Each cycle with resp_i=1 stores burst_i into line bits [64*cnt +: 64] and increments cnt.
  - The beat with cnt=3 moves the FSM to DONE.
- WRITE: write_o=1 and burst_o = line[64*cnt +: 64].
  - Each cycle with resp_i=1 increments cnt.
  - The beat with cnt=3 moves the FSM to DONE.
- Gaps are legal. resp_i may drop between beats, and read_o/write_o stay high until the 4th beat.
- DONE: resp_o=1 for exactly one cycle, then IDLE.
- line_o holds the last completed read line until the next read's first beat overwrites its lower word. The cache must sample line_o in the resp_o cycle.
- resp_i is ignored in IDLE and DONE.
- read_o, write_o and resp_o decode combinationally from state. burst_o is combinational from the line register and cnt.

## Timing
- Reset: state=IDLE, cnt=0, line register 0, address register 0. Consequently resp_o=0, read_o=0, write_o=0, line_o=0, address_o=0, burst_o=0.
- Request sampled at edge t (IDLE). read_o/write_o and address_o are valid from cycle t+1.
- Beats on resp_i at cycles k..k+3 give resp_o in cycle k+4. Minimum total latency is request to resp_o = 5 cycles with no beat gaps.
- Cycle after resp_o is IDLE. A new request is sampled there, so back-to-back lines cost one idle cycle.
- Reset mid-burst: the FSM aborts to IDLE at the reset edge and drops read_o/write_o in the same cycle. Partial read data is discarded and resp_o is not issued.
- cnt is 2 bits and wraps only on the transition to DONE. There are never more than 4 beats per line.

## Structure
- cacheline_adaptor_pkg holds:
  - LINE_W=256, BEAT_W=64, BEATS=4, CNT_W=2
  - typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t.
- One module with no sub-modules. The beat counter and line shift/index register are inline.

## Test plan
- Read, contiguous: address_i=0x0000_1234, read_i held; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles.
  - address_o=0x0000_1220.
  - resp_o for one cycle with line_o = {0x44..,0x33..,0x22..,0x11..}.
  - 5-cycle latency.
- Read with gaps: same as above, but resp_i low for 2 cycles between beats 1 and 2.
  - read_o stays high throughout.
  - Same line_o; resp_o is 2 cycles later.
- Write: line_i = 256'h{D,C,B,A} (64-bit words), address_i=0x8000_0040.
  - burst_o presents A,B,C,D in order, advancing only on resp_i.
  - write_o high until the 4th beat, then one resp_o pulse.
- Read and write both asserted in IDLE: read serviced first with resp_o. The write starts after one idle cycle and completes correctly.
- Reset asserted after 2 read beats: the next cycle is IDLE with read_o=0 and resp_o never pulses. A subsequent read returns a clean new line.
- Stray resp_i in IDLE: no state change, no resp_o, line_o unchanged.
